// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/read/exec/write-back sequencer for an RV32I core.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_CNT_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    input  logic        dec_valid_in,
    input  logic        dec_rs1_read_in,
    input  logic        dec_rs2_read_in,
    input  logic        dec_rd_write_in,
    input  logic        stall_in,
    output logic        rf_rd_en_out,
    output logic        alu_en_out,
    output logic        rf_wr_en_out,
    output logic [31:0] pc_out,
    output logic        retire_out,
    output logic        trap_out,
    output logic [1:0]  trap_cause_out,
    output logic [31:0] instret_out
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StDecode,
        StRead,
        StExec,
        StWb,
        StTrap
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            instr_q, instr_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic                   trap_q, trap_d;
    logic [1:0]             cause_q, cause_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            instr_q <= NopInstr;
            tmo_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        tmo_d        = tmo_q;
        trap_d       = trap_q;
        cause_d      = cause_q;
        imem_req_out = 1'b0;
        rf_rd_en_out = 1'b0;
        alu_en_out   = 1'b0;
        rf_wr_en_out = 1'b0;
        retire_out   = 1'b0;

        unique case (state_q)
            StBoot: begin
                tmo_d   = '0;
                state_d = StFetch;
            end
            StFetch: begin
                imem_req_out = 1'b1;
                // An ack on the last counted cycle still wins over the timeout.
                if (imem_ack_in) begin
                    instr_d = imem_data_in;
                    tmo_d   = '0;
                    state_d = StDecode;
                end else if (tmo_q == '1) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                    state_d = StTrap;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
            end
            StDecode: begin
                if (!dec_valid_in) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                    state_d = StTrap;
                end else if (dec_rs1_read_in || dec_rs2_read_in) begin
                    state_d = StRead;
                end else begin
                    state_d = StExec;
                end
            end
            StRead: begin
                rf_rd_en_out = 1'b1;
                state_d      = StExec;
            end
            StExec: begin
                alu_en_out = 1'b1;
                if (!stall_in) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_wr_en_out = dec_rd_write_in;
                retire_out   = 1'b1;
                pc_d         = pc_q + 32'd4;
                state_d      = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    assign imem_addr_out  = pc_q;
    assign pc_out         = pc_q;
    assign instr_out      = instr_q;
    assign trap_out       = trap_q;
    assign trap_cause_out = cause_q;

`ifdef SEQ_INSTRET_CNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            instret_q <= 32'd0;
        end else if (retire_out) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_out = instret_q;
`else
    assign instret_out = 32'd0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer; per-instruction timing and
// strobe counts are predicted from ack delay, stall length and decoded operands.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data, instr;
    logic        dec_valid, dec_rs1, dec_rs2, dec_rd;
    logic        stall, rf_rd_en, alu_en, rf_wr_en, retire, trap;
    logic [31:0] pc, instret;
    logic [1:0]  trap_cause;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_pc;
    logic [31:0] model_instret;

    core_sequencer #(
        .RESET_PC (RESET_PC),
        .TIMEOUT_W(4)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .imem_req_out   (imem_req),
        .imem_addr_out  (imem_addr),
        .imem_ack_in    (imem_ack),
        .imem_data_in   (imem_data),
        .instr_out      (instr),
        .dec_valid_in   (dec_valid),
        .dec_rs1_read_in(dec_rs1),
        .dec_rs2_read_in(dec_rs2),
        .dec_rd_write_in(dec_rd),
        .stall_in       (stall),
        .rf_rd_en_out   (rf_rd_en),
        .alu_en_out     (alu_en),
        .rf_wr_en_out   (rf_wr_en),
        .pc_out         (pc),
        .retire_out     (retire),
        .trap_out       (trap),
        .trap_cause_out (trap_cause),
        .instret_out    (instret)
    );

    always #5 clk = ~clk;

    // Small RV32I-flavoured decoder: {valid, rs1, rs2, rd}
    function automatic logic [3:0] dec_attr(input logic [31:0] w);
        logic [3:0] a;
        a = 4'b0000;
        case (w[6:0])
            7'h33:               a = 4'b1111;
            7'h13:               a = 4'b1101;
            7'h23, 7'h63:        a = 4'b1110;
            7'h37, 7'h17, 7'h6F: a = 4'b1001;
            default:             a = 4'b0000;
        endcase
        return a;
    endfunction

    always_comb begin
        {dec_valid, dec_rs1, dec_rs2, dec_rd} = dec_attr(instr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef SEQ_INSTRET_CNT_EN
        return model_instret;
`else
        return 32'd0;
`endif
    endfunction

    // Assert reset at a negedge, check async clear, release and land on the first FETCH.
    task automatic do_reset();
        imem_ack = 1'b0;
        stall    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instret", instret, 32'd0);
        check("rst_strobes", 32'({imem_req, rf_rd_en, alu_en, rf_wr_en, retire}), 32'd0);
        model_pc      = RESET_PC;
        model_instret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        check("boot_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("fetch_req", 32'(imem_req), 32'd1);
    endtask

    // Run one instruction starting from a FETCH negedge; returns 1 if it trapped.
    task automatic do_instr(input int delay, input logic [31:0] word, input int stl,
                            output bit trapped);
        logic [3:0] a;
        int fetch_n, rd_n, alu_n, wr_n, ret_n, end_idx, ovl, reads;
        bit done;
        fetch_n = 0; rd_n = 0; alu_n = 0; wr_n = 0; ret_n = 0; end_idx = -1; ovl = 0;
        done = 0; trapped = 0;
        a     = dec_attr(word);
        reads = (a[2] | a[1]) ? 1 : 0;
        check("fetch_addr", imem_addr, model_pc);
        for (int n = 0; n < 80 && !done; n++) begin
            if (trap) begin
                trapped = 1; done = 1; end_idx = n;
            end else begin
                if (imem_req) begin
                    imem_ack = (fetch_n == delay);
                    fetch_n++;
                end else begin
                    imem_ack = 1'b0;
                end
                imem_data = imem_ack ? word : $urandom;
                if (rf_rd_en) rd_n++;
                if (alu_en) begin
                    alu_n++;
                    stall = (alu_n <= stl);
                end else begin
                    stall = 1'b0;
                end
                if (rf_wr_en) wr_n++;
                if (32'(imem_req) + 32'(rf_rd_en) + 32'(alu_en) + 32'(retire) > 1) ovl++;
                if (retire) begin
                    ret_n++; done = 1; end_idx = n;
                end
                if (!done) @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        check("bounded", 32'(done), 32'd1);
        check("overlap", 32'(ovl), 32'd0);

        if (delay >= TMO || !a[3]) begin
            check("trap_taken", 32'(trapped), 32'd1);
            check("trap_idx", 32'(end_idx), (delay >= TMO) ? 32'(TMO) : 32'(delay + 2));
            check("trap_cause", 32'(trap_cause), (delay >= TMO) ? 32'd2 : 32'd1);
            check("trap_fetches", 32'(fetch_n), (delay >= TMO) ? 32'(TMO) : 32'(delay + 1));
            check("trap_nowr", 32'(wr_n + ret_n), 32'd0);
            repeat (3) @(negedge clk);
            check("trap_sticky", 32'({trap, trap_cause}), (delay >= TMO) ? 32'h6 : 32'h5);
            check("trap_pc", pc, model_pc);
            check("trap_quiet", 32'({imem_req, rf_rd_en, alu_en, rf_wr_en, retire}), 32'd0);
            check("trap_instret", instret, exp_instret());
        end else begin
            check("retired", 32'(trapped), 32'd0);
            check("ret_idx", 32'(end_idx), 32'(delay + reads + stl + 3));
            check("rd_cnt", 32'(rd_n), 32'(reads));
            check("alu_cnt", 32'(alu_n), 32'(stl + 1));
            check("wr_cnt", 32'(wr_n), 32'(a[0]));
            model_pc      = model_pc + 32'd4;
            model_instret = model_instret + 32'd1;
            @(negedge clk);
            check("next_pc", pc, model_pc);
            check("next_req", 32'(imem_req), 32'd1);
            check("instret", instret, exp_instret());
        end
    endtask

    bit          t;
    logic [31:0] rw;
    logic [6:0]  ops [8] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        stall     = 1'b0;
        @(negedge clk);
        do_reset();

        do_instr(1, 32'h0050_0093, 0, t);   // ADDI, wraps pc to 0
        repeat (3) do_instr(0, 32'h0020_81B3, 0, t);
        do_instr(0, 32'h0020_81B3, 3, t);
        do_instr(15, 32'h0050_0093, 0, t);
        do_instr(16, 32'h0050_0093, 0, t);
        do_reset();
        do_instr(0, 32'hFFFF_FFFF, 0, t);
        do_reset();

        // Reset while held in EXEC abandons the instruction.
        imem_ack  = 1'b1;
        imem_data = 32'h0020_81B3;
        stall     = 1'b1;
        for (int i = 0; i < 10 && !alu_en; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            check("exec_nowr", 32'({rf_wr_en, retire}), 32'd0);
        end
        check("exec_reached", 32'(alu_en), 32'd1);
        do_reset();

        for (int k = 0; k < 60; k++) begin
            rw = $urandom;
            rw[6:0] = ops[$urandom_range(0, 7)];
            do_instr(($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 16))
                                                 : int'($urandom_range(0, 3)),
                     rw, int'($urandom_range(0, 3)), t);
            if (t) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
